// File: rtl/jk_sync_counter_if.sv
// Bus bundle for jk_sync_counter: count controls in, JK state and excitation out.
// The master drives the controls; the counter (slave) drives state, excitation and flags.
interface jk_sync_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qb;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             tc;
  logic             load_err;

  modport master (
    output en, up_dn, load, load_val,
    input  Q, Qb, J, K, tc, load_err
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output Q, Qb, J, K, tc, load_err
  );
endinterface

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter held in JK cells; exports the per-bit J/K
// excitation so downstream JK stages can be driven and cross-checked.
module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  jk_sync_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             load_err_q;
  logic             load_err_d;
  logic             load_ok;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] q_inc;
  logic [WIDTH-1:0] q_dec;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic [WIDTH-1:0] q_jk;

  // With MODULUS == 2**WIDTH every load_val is in range, so nothing is rejected.
  assign load_ok = ({1'b0, bus.load_val} < MOD_EXT);
  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);
  assign q_inc   = at_max  ? '0      : q_q + 1'b1;
  assign q_dec   = at_zero ? MAX_VAL : q_q - 1'b1;

  // Target value N; reset is kept out so J/K still reflect the inputs under rst.
  always_comb begin
    q_d        = q_q;
    load_err_d = 1'b0;
    if (bus.load) begin
      if (load_ok) begin
        q_d = bus.load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (bus.en) begin
      q_d = bus.up_dn ? q_inc : q_dec;
    end
  end

  assign j_vec = ~q_q & q_d;
  assign k_vec = q_q & ~q_d;
  assign q_jk  = (j_vec & ~q_q) | (~k_vec & q_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      load_err_q <= 1'b0;
    end else begin
      q_q        <= q_jk;
      load_err_q <= load_err_d;
    end
  end

  assign bus.Q        = q_q;
  assign bus.Qb       = ~q_q;
  assign bus.J        = j_vec;
  assign bus.K        = k_vec;
  assign bus.load_err = load_err_q;
  assign bus.tc       = bus.en & ~bus.load &
                        ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));

  a_jk_tracks_n: assert property (@(posedge clk) !rst |=> (q_q == $past(q_d)));
  a_jk_exclusive: assert property (@(posedge clk) (j_vec & k_vec) == '0);

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench for jk_sync_counter: tasks push expected state per edge,
// a monitor pops and compares; a behavioural JK bank tracks the exported J/K.
module tb_jk_sync_counter;
  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   mq = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_err[$];
  logic [WIDTH-1:0] bank_q;

  jk_sync_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_sync_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) bank_q <= '0;
    else     bank_q <= (bus.J & ~bank_q) | (~bus.K & bank_q);
  end

  function automatic int model_n(input int q, input bit use_rst);
    if (use_rst && rst) return 0;
    if (bus.load) return (int'(bus.load_val) < MODULUS) ? int'(bus.load_val) : q;
    if (bus.en) return bus.up_dn ? (q + 1) % MODULUS : (q + MODULUS - 1) % MODULUS;
    return q;
  endfunction

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic [WIDTH-1:0] lv);
    rst          = r;
    bus.en       = e;
    bus.up_dn    = u;
    bus.load     = l;
    bus.load_val = lv;
  endtask

  task automatic tick();
    int n;
    n = model_n(mq, 1'b1);
    exp_q.push_back(WIDTH'(n));
    exp_err.push_back(!rst && bus.load && (int'(bus.load_val) >= MODULUS));
    @(posedge clk);
    #2;
    mq = n;
  endtask

  always @(posedge clk) begin
    logic [WIDTH-1:0] eq;
    logic             ee;
    #1;
    if (exp_q.size() != 0) begin
      eq = exp_q.pop_front();
      ee = exp_err.pop_front();
      checks++;
      if (bus.Q !== eq) begin
        errors++;
        $display("FAIL sb_q got=%h exp=%h t=%0t", bus.Q, eq, $time);
      end
      checks++;
      if (bus.Qb !== ~eq) begin
        errors++;
        $display("FAIL sb_qb got=%h exp=%h t=%0t", bus.Qb, ~eq, $time);
      end
      checks++;
      if (bus.load_err !== ee) begin
        errors++;
        $display("FAIL sb_load_err got=%b exp=%b t=%0t", bus.load_err, ee, $time);
      end
      checks++;
      if (bank_q !== eq) begin
        errors++;
        $display("FAIL sb_bank got=%h exp=%h t=%0t", bank_q, eq, $time);
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    tick();
    checks++;
    if (bus.Qb !== 4'hF) begin
      errors++;
      $display("FAIL reset_qb got=%h exp=f", bus.Qb);
    end
    #1;
    checks++;
    if (bus.J !== 4'b0101 || bus.K !== 4'b0000) begin
      errors++;
      $display("FAIL reset_jk got=%b/%b exp=0101/0000", bus.J, bus.K);
    end
    tick();
    checks++;
    if (bus.Q !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=0", bus.Q);
    end
  endtask

  task automatic test_count_up();
    logic [WIDTH-1:0] seq [12];
    seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (bus.tc !== (mq == MODULUS - 1)) begin
        errors++;
        $display("FAIL up_tc[%0d] got=%b q=%0d", i, bus.tc, mq);
      end
      tick();
      checks++;
      if (bus.Q !== seq[i]) begin
        errors++;
        $display("FAIL up_seq[%0d] got=%h exp=%h", i, bus.Q, seq[i]);
      end
    end
  endtask

  task automatic test_count_down();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    #1;
    checks++;
    if (bus.tc !== 1'b1 || bus.J !== 4'b1001 || bus.K !== 4'b0000) begin
      errors++;
      $display("FAIL down_wrap_exc tc=%b J=%b K=%b exp 1/1001/0000", bus.tc, bus.J, bus.K);
    end
    tick();
    checks++;
    if (bus.Q !== 4'd9) begin
      errors++;
      $display("FAIL down_q9 got=%h exp=9", bus.Q);
    end
    tick();
    checks++;
    if (bus.Q !== 4'd8) begin
      errors++;
      $display("FAIL down_q8 got=%h exp=8", bus.Q);
    end
  endtask

  task automatic test_load_priority();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    tick();
    checks++;
    if (bus.Q !== 4'd7) begin
      errors++;
      $display("FAIL load7 got=%h exp=7", bus.Q);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    #1;
    checks++;
    if (bus.J !== 4'b1000 || bus.K !== 4'b0111) begin
      errors++;
      $display("FAIL exc_7to8 got=%b/%b exp=1000/0111", bus.J, bus.K);
    end
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
    tick();
    checks++;
    if (bus.Q !== 4'd8 || bus.load_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_load q=%h err=%b exp=8/1", bus.Q, bus.load_err);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    checks++;
    if (bus.load_err !== 1'b0) begin
      errors++;
      $display("FAIL bad_load_pulse got=%b exp=0", bus.load_err);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
    tick();
    tick();
    checks++;
    if (bus.load_err !== 1'b1 || bus.Q !== 4'd8) begin
      errors++;
      $display("FAIL b2b_bad_load err=%b q=%h exp=1/8", bus.load_err, bus.Q);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
    tick();
    #1;
    checks++;
    if (bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL tc_masked_by_load got=%b exp=0", bus.tc);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (bus.Q !== 4'd5) begin
      errors++;
      $display("FAIL mid_pre got=%h exp=5", bus.Q);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    tick();
    checks++;
    if (bus.Q !== 4'd0) begin
      errors++;
      $display("FAIL mid_rst got=%h exp=0", bus.Q);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    tick();
    checks++;
    if (bus.Q !== 4'd2) begin
      errors++;
      $display("FAIL mid_resume got=%h exp=2", bus.Q);
    end
  endtask

  task automatic test_direction_flip();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    checks++;
    if (bus.Q !== 4'd0) begin
      errors++;
      $display("FAIL flip_up_wrap got=%h exp=0", bus.Q);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    checks++;
    if (bus.Q !== 4'd9) begin
      errors++;
      $display("FAIL flip_down_wrap got=%h exp=9", bus.Q);
    end
  endtask

  task automatic test_random();
    int n;
    logic etc;
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), WIDTH'($urandom_range(0, 15)));
      #1;
      n = model_n(mq, 1'b0);
      etc = bus.en & ~bus.load & ((bus.up_dn & (mq == MODULUS - 1)) | (~bus.up_dn & (mq == 0)));
      checks++;
      if (bus.J !== (~WIDTH'(mq) & WIDTH'(n)) || bus.K !== (WIDTH'(mq) & ~WIDTH'(n)) || bus.tc !== etc) begin
        errors++;
        $display("FAIL rnd_exc[%0d] J=%b K=%b tc=%b q=%0d n=%0d", i, bus.J, bus.K, bus.tc, mq, n);
      end
      tick();
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    test_reset();
    test_count_up();
    test_count_down();
    test_load_priority();
    test_mid_reset();
    test_direction_flip();
    test_random();
    #10;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
